sram_axil: RTL and testbench
============================

SRAM_AXIL -- requirements
Module: sram_axil

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits; multiple of 8.
REQ-003 SHALL have parameter DEPTH_LOG2, default 12, log2 of the number of DATA_W words stored.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-005 SHALL have parameter RD_LAT, default 1, range 1..255, cycles from AR handshake to rvalid.
REQ-006 SHALL have parameter WR_LAT, default 1, range 1..255, cycles from last of AW/W handshake to bvalid.
REQ-007 SHALL have ports: clk input 1, the single clock; rst input 1, reset, asynchronous and active-low.
REQ-008 SHALL have read ports: arvalid in 1; arready out 1; araddr in ADDR_W; rvalid out 1; rready in 1; rdata out DATA_W; rresp out 2.
REQ-009 SHALL have write ports: awvalid in 1; awready out 1; awaddr in ADDR_W; wvalid in 1; wready out 1; wdata in DATA_W; wstrb in DATA_W/8; bvalid out 1; bready in 1; bresp out 2.

Function
REQ-010 SHALL hold 2^DEPTH_LOG2 words; index = (addr - BASE_ADDR) >> log2(DATA_W/8); low byte-offset bits ignored.
REQ-011 SHALL flag an address as out of range when addr < BASE_ADDR or index >= 2^DEPTH_LOG2.
REQ-012 SHALL implement read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE; arready = 1 only in R_IDLE (registered).
REQ-013 SHALL on arvalid && arready capture araddr, load latency counter, enter R_WAIT.
REQ-014 SHALL assert rvalid exactly RD_LAT cycles after the AR handshake edge, sampling the memory at that edge.
REQ-015 SHALL hold rvalid, rdata, rresp stable until rvalid && rready, then return to R_IDLE; next arready one cycle later.
REQ-016 SHALL return rresp 2'b00 in range; 2'b10 with rdata 0 when out of range.
REQ-017 SHALL implement write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE; awready and wready independent, each high in W_IDLE until its own handshake.
REQ-018 SHALL buffer whichever of AW/W arrives first, dropping that ready; enter W_WAIT when both captured (same or different cycles).
REQ-019 SHALL commit the write, byte lanes per wstrb, at the edge bvalid rises, WR_LAT cycles after entering W_WAIT.
REQ-020 SHALL suppress the commit and return bresp 2'b10 when out of range; else bresp 2'b00.
REQ-021 SHALL hold bvalid, bresp until bvalid && bready, then return to W_IDLE.
REQ-022 SHALL let read and write channels run concurrently; a read sampled at the same edge as a write commit to the same word returns pre-write data.
REQ-023 SHALL treat wstrb = 0 in range as a completed no-op write with bresp 2'b00.

Reset
REQ-024 SHALL on rst low, asynchronously: arready, rvalid, awready, wready, bvalid = 0; rdata = 0; rresp = bresp = 2'b00; both FSMs idle; counters 0.
REQ-025 SHALL drop any in-flight transaction on reset without committing it; memory contents are not cleared.
REQ-026 SHALL assert arready, awready, wready on the first clk edge after rst goes high.

Configuration
REQ-027 SHALL, with macro SRAM_RAND_DELAY_EN defined, run a 4-bit LFSR (x^4+x^3+1, seed 4'b1001 at reset) advancing every cycle.
REQ-028 SHALL, with SRAM_RAND_DELAY_EN defined, add lfsr[2:0] (0..7) extra cycles to RD_LAT or WR_LAT, sampled at the respective handshake that starts the wait.
REQ-029 SHALL, without SRAM_RAND_DELAY_EN, use exactly RD_LAT / WR_LAT with no LFSR logic present.

Verification
REQ-030 SHALL cover: write addr 0x8000_0010, data 0xDEADBEEF, wstrb 4'hF, then read -> bresp 00, rdata 0xDEADBEEF, rvalid RD_LAT cycles after AR handshake.
REQ-031 SHALL cover: wstrb 4'b0010 data 0x0000_AA00 over 0x11223344 -> read returns 0x1122AA44.
REQ-032 SHALL cover: W presented 3 cycles before AW -> wready drops after W handshake, bvalid WR_LAT cycles after AW handshake, data committed.
REQ-033 SHALL cover: read 0x7FFF_FFFC and 0x8000_4000 (DEPTH_LOG2=12) -> rresp 2'b10, rdata 0; write there -> bresp 2'b10, memory unchanged.
REQ-034 SHALL cover: rready held low 5 cycles -> rvalid/rdata stable 5 cycles, arready low throughout.
REQ-035 SHALL cover: rst low during W_WAIT -> all outputs 0 immediately, target word unchanged after reset.

Source files
------------

// File: rtl/sram_axil.sv
// AXI4-Lite SRAM slave: independent read/write FSMs with fixed latency.
// Optional macro SRAM_RAND_DELAY_EN adds 0..7 LFSR cycles per access.
module sram_axil #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int RD_LAT     = 1,
  parameter int WR_LAT     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CNT_W  = 9;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) ||
           ((off >> (OFF_W + DEPTH_LOG2)) != '0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] idx(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[OFF_W +: DEPTH_LOG2];
  endfunction

  logic [2:0] extra;

`ifdef SRAM_RAND_DELAY_EN
  logic [3:0] lfsr;

  // Free-running x^4+x^3+1 LFSR for extra access delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 4'b1001;
    else      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  assign extra = lfsr[2:0];
`else
  assign extra = 3'd0;
`endif

  // ---------------- read channel ----------------
  r_state_t          r_state, r_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              ar_hs, r_hs;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // Read state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  // Read next-state
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_WAIT;
      R_WAIT: if (r_cnt == '0) r_next = R_RESP;
      R_RESP: if (r_hs) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read datapath: address capture, latency count, response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      arready <= (r_next == R_IDLE);
      if (ar_hs) begin
        r_addr <= araddr;
        r_cnt  <= CNT_W'(RD_LAT - 1) + CNT_W'(extra);
      end else if (r_state == R_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == R_WAIT && r_cnt == '0) begin
        rvalid <= 1'b1;
        if (oor(r_addr)) begin
          rdata <= '0;
          rresp <= 2'b10;
        end else begin
          rdata <= mem[idx(r_addr)];
          rresp <= 2'b00;
        end
      end else if (r_hs) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t          w_state, w_next;
  logic [CNT_W-1:0]  w_cnt;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              aw_got, w_got;
  logic              aw_hs, w_hs, b_hs;
  logic              aw_have, w_have;
  logic              wr_en;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign b_hs    = bvalid && bready;
  assign aw_have = aw_got || aw_hs;
  assign w_have  = w_got || w_hs;
  assign wr_en   = (w_state == W_WAIT) && (w_cnt == '0) &&
                   !oor(aw_addr);

  // Write state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  // Write next-state
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (aw_have && w_have) w_next = W_WAIT;
      W_WAIT: if (w_cnt == '0) w_next = W_RESP;
      W_RESP: if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write datapath: AW/W buffering, latency count, response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_cnt   <= '0;
    end else begin
      if (aw_hs) aw_addr <= awaddr;
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      aw_got  <= (w_next == W_IDLE) && aw_have;
      w_got   <= (w_next == W_IDLE) && w_have;
      awready <= (w_next == W_IDLE) && !aw_have;
      wready  <= (w_next == W_IDLE) && !w_have;
      if (w_state == W_IDLE && w_next == W_WAIT) begin
        w_cnt <= CNT_W'(WR_LAT - 1) + CNT_W'(extra);
      end else if (w_state == W_WAIT && w_cnt != '0) begin
        w_cnt <= w_cnt - 1'b1;
      end
      if (w_state == W_WAIT && w_cnt == '0) begin
        bvalid <= 1'b1;
        bresp  <= oor(aw_addr) ? 2'b10 : 2'b00;
      end else if (b_hs) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Byte-lane commit at the edge bvalid rises
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) begin
          mem[idx(aw_addr)][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_axil.sv
// Scoreboard bench for sram_axil: queued expectations, negedge monitor,
// word-level reference memory.
module tb_sram_axil;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DL = 12;
  localparam int RL = 2;
  localparam int WL = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  logic arvalid, arready, rvalid, rready;
  logic [AW-1:0] araddr;
  logic [DW-1:0] rdata;
  logic [1:0] rresp, bresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;

  sram_axil #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL),
    .BASE_ADDR(BASE), .RD_LAT(RL), .WR_LAT(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          hs;
  } rexp_t;
  typedef struct {
    logic [1:0] resp;
    int         hs;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  logic [31:0] mm [int];

  int checks = 0;
  int failures = 0;
  bit hold_r = 0;
  bit rnd_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return off >= 0 && (off / 4) < (64'd1 << DL);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    logic [31:0] w;
    if (!in_rng(a)) return;
    w = mm.exists(widx(a)) ? mm[widx(a)] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mm[widx(a)] = w;
  endtask

  task automatic do_read(input logic [31:0] a);
    bit ok;
    rexp_t e;
    ok = 0;
    arvalid = 1'b1;
    araddr = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    chk("ar_handshake", ok, 1);
    if (!ok) begin arvalid = 1'b0; return; end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    e.hs = cyc;
    if (in_rng(a)) begin
      e.data = mm[widx(a)];
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    rq.push_back(e);
  endtask

  task automatic chan_aw(input logic [31:0] a, output int hs);
    bit ok;
    ok = 0;
    hs = -1;
    awvalid = 1'b1;
    awaddr = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    chk("aw_handshake", ok, 1);
    if (!ok) begin awvalid = 1'b0; return; end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    hs = cyc;
    chk("awready_drop", awready, 0);
  endtask

  task automatic chan_w(input logic [31:0] d, input logic [3:0] s,
                        output int hs);
    bit ok;
    ok = 0;
    hs = -1;
    wvalid = 1'b1;
    wdata = d;
    wstrb = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    chk("w_handshake", ok, 1);
    if (!ok) begin wvalid = 1'b0; return; end
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    hs = cyc;
    chk("wready_drop", wready, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly,
                          input int w_dly, input bit push);
    int ha, hw;
    bexp_t e;
    fork
      begin
        repeat (aw_dly) @(posedge clk);
        if (aw_dly > 0) #1;
        chan_aw(a, ha);
      end
      begin
        repeat (w_dly) @(posedge clk);
        if (w_dly > 0) #1;
        chan_w(d, s, hw);
      end
    join
    if (!push || ha < 0 || hw < 0) return;
    e.hs = (ha > hw) ? ha : hw;
    e.resp = in_rng(a) ? 2'b00 : 2'b10;
    bq.push_back(e);
    model_write(a, d, s);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (rq.size() == 0 && bq.size() == 0) begin ok = 1; break; end
    end
    chk("idle_timeout", ok, 1);
    if (!ok) begin rq.delete(); bq.delete(); end
    #1;
  endtask

  // Ready drivers: always high, held low on request, or random
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!hold_r) rready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every presented response against the queue head
  initial begin
    bit rp, bp;
    rp = 0;
    bp = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rp = 0;
        bp = 0;
      end else begin
        if (rvalid) begin
          if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL r_unexpected rvalid=1 expected=0");
          end else begin
            if (!rp) chk("r_latency", cyc - rq[0].hs, RL);
            chk("arready_low", arready, 0);
            chk("rdata", rdata, rq[0].data);
            chk("rresp", rresp, rq[0].resp);
            if (rready) void'(rq.pop_front());
          end
        end
        if (bvalid) begin
          if (bq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected bvalid=1 expected=0");
          end else begin
            if (!bp) chk("b_latency", cyc - bq[0].hs, WL);
            chk("bresp", bresp, bq[0].resp);
            if (bready) void'(bq.pop_front());
          end
        end
        rp = rvalid;
        bp = bvalid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rresp"}, rresp, 0);
    chk({tag, "_bresp"}, bresp, 0);
  endtask

  task automatic chk_readies(input string tag);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_wready"}, wready, 1);
  endtask

  initial begin
    logic [31:0] a;
    bit ok;
    arvalid = 0; awvalid = 0; wvalid = 0;
    araddr = 0; awaddr = 0; wdata = 0; wstrb = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_readies("post_reset");

    // full-word write then read back
    do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 1);
    wait_idle();
    do_read(32'h8000_0010);
    wait_idle();

    // single byte lane
    do_write(32'h8000_0020, 32'h11223344, 4'hF, 0, 0, 1);
    wait_idle();
    do_write(32'h8000_0020, 32'h0000AA00, 4'b0010, 0, 0, 1);
    wait_idle();
    do_read(32'h8000_0020);
    wait_idle();

    // W leads AW by 3 cycles, then AW leads W by 2
    do_write(32'h8000_0030, 32'hCAFEF00D, 4'hF, 3, 0, 1);
    wait_idle();
    do_read(32'h8000_0030);
    wait_idle();
    do_write(32'h8000_0034, 32'h0BADC0DE, 4'hF, 0, 2, 1);
    wait_idle();
    do_read(32'h8000_0034);
    wait_idle();

    // out-of-range on both sides; aliased words must stay intact
    do_write(32'h8000_0000, 32'hA5A5A5A5, 4'hF, 0, 0, 1);
    wait_idle();
    do_write(32'h8000_3FFC, 32'h5A5A5A5A, 4'hF, 0, 0, 1);
    wait_idle();
    do_read(32'h7FFF_FFFC);
    wait_idle();
    do_read(32'h8000_4000);
    wait_idle();
    do_write(32'h7FFF_FFFC, 32'h12345678, 4'hF, 0, 0, 1);
    wait_idle();
    do_write(32'h8000_4000, 32'h87654321, 4'hF, 0, 0, 1);
    wait_idle();
    do_read(32'h8000_0000);
    wait_idle();
    do_read(32'h8000_3FFC);
    wait_idle();

    // rready held low for 5 cycles
    hold_r = 1;
    rready = 1'b0;
    do_read(32'h8000_0010);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; break; end
    end
    chk("rvalid_seen", ok, 1);
    repeat (5) @(posedge clk);
    #1;
    hold_r = 0;
    rready = 1'b1;
    wait_idle();

    // reset during the write wait: no commit, outputs cleared
    do_write(32'h8000_0010, 32'h01020304, 4'hF, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_readies("rerelease");
    do_read(32'h8000_0010);
    wait_idle();

    // randomized traffic over a small window plus stray addresses
    rnd_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      do_write(BASE + 32'h100 + 32'(i * 4), $urandom, 4'hF, 0, 0, 1);
      wait_idle();
    end
    for (int n = 0; n < 60; n++) begin
      int op;
      op = $urandom_range(0, 3);
      a = BASE + 32'h100 + 32'($urandom_range(0, 15) * 4) +
          32'($urandom_range(0, 3));
      if (op == 3) begin
        a = $urandom_range(0, 1) ? BASE - 32'($urandom_range(1, 64))
                                 : BASE + 32'h4000 +
                                   32'($urandom_range(0, 255));
        op = $urandom_range(0, 1);
      end
      if (op == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1);
      else
        do_read(a);
      wait_idle();
    end
    rnd_rdy = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
